// File: rtl/veriyolu_hakemi_if.sv
// ----------------------------------------------------------------------------
// veriyolu_hakemi_if
// Purpose : external memory bus between the arbiter (master) and the memory
//           (slave). One request at a time, completed by iomem_ready.
// Signals : iomem_valid  request active, fields below are stable while high
//           iomem_wstrb  byte write strobes, 0 means read
//           iomem_addr   request address
//           iomem_wdata  write data
//           iomem_ready  completion from memory
//           iomem_rdata  read data, meaningful with iomem_ready
// ----------------------------------------------------------------------------
interface veriyolu_hakemi_if;
   logic        iomem_valid;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic        iomem_ready;
   logic [31:0] iomem_rdata;

   modport master (
      output iomem_valid,
      output iomem_wstrb,
      output iomem_addr,
      output iomem_wdata,
      input  iomem_ready,
      input  iomem_rdata
   );

   modport slave (
      input  iomem_valid,
      input  iomem_wstrb,
      input  iomem_addr,
      input  iomem_wdata,
      output iomem_ready,
      output iomem_rdata
   );
endinterface

// File: rtl/veriyolu_hakemi.sv
// ----------------------------------------------------------------------------
// veriyolu_hakemi
// Purpose : arbitrates an instruction-cache refill port (ib_*) and a data-cache
//           port (vb_*) onto a single external memory bus. Data requests win by
//           default; after AC_SINIR consecutive data grants while an
//           instruction request waits, the instruction side is served. A
//           transaction that sees no iomem_ready for ZAMAN_ASIMI cycles is
//           aborted with hata_o and a zero-data ready pulse to its owner.
// Ports   : clk, resetn        clock, synchronous active-low reset
//           ib_valid_i/addr_i  instruction read request (held until ready)
//           ib_ready_o/rdata_o instruction completion pulse and read data
//           vb_valid_i/wstrb_i/addr_i/wdata_i  data request (held until ready)
//           vb_ready_o/rdata_o data completion pulse and read data
//           mem                external bus, master side
//           hata_o             one-cycle timeout abort pulse
// ----------------------------------------------------------------------------
module veriyolu_hakemi #(
   parameter int AC_SINIR    = 4,
   parameter int ZAMAN_ASIMI = 255
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      ib_valid_i,
   input  logic [31:0]               ib_addr_i,
   output logic                      ib_ready_o,
   output logic [31:0]               ib_rdata_o,
   input  logic                      vb_valid_i,
   input  logic [3:0]                vb_wstrb_i,
   input  logic [31:0]               vb_addr_i,
   input  logic [31:0]               vb_wdata_i,
   output logic                      vb_ready_o,
   output logic [31:0]               vb_rdata_o,
   veriyolu_hakemi_if.master         mem,
   output logic                      hata_o
);

   localparam int AC_W  = $clog2(AC_SINIR + 1);
   localparam int TMO_W = $clog2(ZAMAN_ASIMI + 1);
   localparam logic [AC_W-1:0]  AC_MAX   = AC_W'(AC_SINIR);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ZAMAN_ASIMI - 1);

   typedef enum logic [1:0] {
      BOS      = 2'd0,
      IB_AKTIF = 2'd1,
      VB_AKTIF = 2'd2
   } durum_t;

   durum_t           state;
   logic             valid_q;
   logic [3:0]       wstrb_q;
   logic [31:0]      addr_q;
   logic [31:0]      wdata_q;
   logic             ib_abort_q;
   logic             vb_abort_q;
   logic             hata_q;
   logic [AC_W-1:0]  ac_cnt;
   logic [TMO_W-1:0] tmo_cnt;

   logic ib_win;
   logic cmpl;
   logic ib_cmpl;
   logic vb_cmpl;

   // The instruction side wins when it is alone or when it has been passed
   // over AC_SINIR times in a row; otherwise a pending data request wins.
   assign ib_win = ib_valid_i && (!vb_valid_i || (ac_cnt == AC_MAX));

   // A bus completion only counts while our request is actually on the bus.
   // Holding resetn low suppresses it so an abandoned transaction never
   // reports back to its owner.
   assign cmpl    = resetn && valid_q && mem.iomem_ready;
   assign ib_cmpl = cmpl && (state == IB_AKTIF);
   assign vb_cmpl = cmpl && (state == VB_AKTIF);

   // Normal completions are passed straight through in the completing cycle;
   // timeout aborts come from registers and carry zero data.
   assign ib_ready_o = ib_cmpl || ib_abort_q;
   assign vb_ready_o = vb_cmpl || vb_abort_q;
   assign ib_rdata_o = ib_cmpl ? mem.iomem_rdata : 32'h0;
   assign vb_rdata_o = vb_cmpl ? mem.iomem_rdata : 32'h0;
   assign hata_o     = hata_q;

   assign mem.iomem_valid = valid_q;
   assign mem.iomem_wstrb = wstrb_q;
   assign mem.iomem_addr  = addr_q;
   assign mem.iomem_wdata = wdata_q;

   // Arbiter FSM. Grants are only made from BOS, so every transaction is
   // separated from the next by at least one idle bus cycle. Request fields
   // are captured at grant time and held until the transaction ends, which
   // keeps the bus stable even if the requester changes its inputs.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= BOS;
         valid_q    <= 1'b0;
         wstrb_q    <= 4'h0;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         ib_abort_q <= 1'b0;
         vb_abort_q <= 1'b0;
         hata_q     <= 1'b0;
         ac_cnt     <= '0;
         tmo_cnt    <= '0;
      end else begin
         ib_abort_q <= 1'b0;
         vb_abort_q <= 1'b0;
         hata_q     <= 1'b0;
         case (state)
            BOS: begin
               if (ib_win) begin
                  state   <= IB_AKTIF;
                  valid_q <= 1'b1;
                  addr_q  <= ib_addr_i;
                  wstrb_q <= 4'h0;
                  wdata_q <= 32'h0;
                  tmo_cnt <= '0;
               end else if (vb_valid_i) begin
                  state   <= VB_AKTIF;
                  valid_q <= 1'b1;
                  addr_q  <= vb_addr_i;
                  wstrb_q <= vb_wstrb_i;
                  wdata_q <= vb_wdata_i;
                  tmo_cnt <= '0;
               end
               // Starvation count only tracks data grants that bypassed a
               // waiting instruction request.
               if (!ib_valid_i || ib_win) begin
                  ac_cnt <= '0;
               end else if (vb_valid_i && (ac_cnt != AC_MAX)) begin
                  ac_cnt <= ac_cnt + 1'b1;
               end
            end
            IB_AKTIF, VB_AKTIF: begin
               // A ready in the last waiting cycle still counts as success.
               if (mem.iomem_ready) begin
                  state   <= BOS;
                  valid_q <= 1'b0;
               end else if (tmo_cnt == TMO_LAST) begin
                  state      <= BOS;
                  valid_q    <= 1'b0;
                  hata_q     <= 1'b1;
                  ib_abort_q <= (state == IB_AKTIF);
                  vb_abort_q <= (state == VB_AKTIF);
                  tmo_cnt    <= tmo_cnt + 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            default: begin
               state   <= BOS;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_veriyolu_hakemi.sv
// ----------------------------------------------------------------------------
// tb_veriyolu_hakemi
// Purpose : directed self-checking bench for veriyolu_hakemi, built with
//           AC_SINIR=4 and ZAMAN_ASIMI=8. Inputs change 2 time units after a
//           rising edge; outputs are checked 1 time unit later.
// ----------------------------------------------------------------------------
module tb_veriyolu_hakemi;

   localparam int AC_SINIR    = 4;
   localparam int ZAMAN_ASIMI = 8;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        ib_valid_i = 1'b0;
   logic [31:0] ib_addr_i = 32'h0;
   logic        ib_ready_o;
   logic [31:0] ib_rdata_o;
   logic        vb_valid_i = 1'b0;
   logic [3:0]  vb_wstrb_i = 4'h0;
   logic [31:0] vb_addr_i = 32'h0;
   logic [31:0] vb_wdata_i = 32'h0;
   logic        vb_ready_o;
   logic [31:0] vb_rdata_o;
   logic        hata_o;

   int tests_run    = 0;
   int tests_failed = 0;

   veriyolu_hakemi_if bus ();

   veriyolu_hakemi #(
      .AC_SINIR    (AC_SINIR),
      .ZAMAN_ASIMI (ZAMAN_ASIMI)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .ib_valid_i (ib_valid_i),
      .ib_addr_i  (ib_addr_i),
      .ib_ready_o (ib_ready_o),
      .ib_rdata_o (ib_rdata_o),
      .vb_valid_i (vb_valid_i),
      .vb_wstrb_i (vb_wstrb_i),
      .vb_addr_i  (vb_addr_i),
      .vb_wdata_i (vb_wdata_i),
      .vb_ready_o (vb_ready_o),
      .vb_rdata_o (vb_rdata_o),
      .mem        (bus.slave),
      .hata_o     (hata_o)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Drives every requester and memory-side input in one go.
   task automatic applyStimulus(input logic ibv, input logic [31:0] iba,
                                input logic vbv, input logic [3:0] vbs,
                                input logic [31:0] vba, input logic [31:0] vbd,
                                input logic rdy, input logic [31:0] rd);
      ib_valid_i      = ibv;
      ib_addr_i       = iba;
      vb_valid_i      = vbv;
      vb_wstrb_i      = vbs;
      vb_addr_i       = vba;
      vb_wdata_i      = vbd;
      bus.iomem_ready = rdy;
      bus.iomem_rdata = rd;
   endtask

   // One comparison: counts it and reports a failure with both values.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   // Directed sequence covering reset, a single instruction read, starvation
   // relief, field stability, timeout, timeout-boundary completion and reset
   // during an active transaction.
   initial begin
      // ---- reset state
      applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
      resetn = 1'b0;
      tick();
      tick();
      checkOutput("rst_valid", 32'(bus.iomem_valid), 32'd0);
      checkOutput("rst_addr",  bus.iomem_addr, 32'h0);
      checkOutput("rst_wstrb", 32'(bus.iomem_wstrb), 32'h0);
      checkOutput("rst_wdata", bus.iomem_wdata, 32'h0);
      checkOutput("rst_ib_ready", 32'(ib_ready_o), 32'd0);
      checkOutput("rst_vb_ready", 32'(vb_ready_o), 32'd0);
      checkOutput("rst_hata", 32'(hata_o), 32'd0);

      // ---- single instruction read, memory answers in the third active cycle
      resetn = 1'b1;
      applyStimulus(1'b1, 32'h0000_1000, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
      settle();
      checkOutput("ib_req_valid_lat", 32'(bus.iomem_valid), 32'd0);
      tick();
      checkOutput("ib_valid", 32'(bus.iomem_valid), 32'd1);
      checkOutput("ib_addr", bus.iomem_addr, 32'h0000_1000);
      checkOutput("ib_wstrb", 32'(bus.iomem_wstrb), 32'h0);
      checkOutput("ib_wdata", bus.iomem_wdata, 32'h0);
      checkOutput("ib_wait_ready", 32'(ib_ready_o), 32'd0);
      checkOutput("ib_wait_rdata", ib_rdata_o, 32'h0);
      tick();
      tick();
      applyStimulus(1'b1, 32'h0000_1000, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h1234_5678);
      settle();
      checkOutput("ib_done_ready", 32'(ib_ready_o), 32'd1);
      checkOutput("ib_done_rdata", ib_rdata_o, 32'h1234_5678);
      checkOutput("ib_done_vb_ready", 32'(vb_ready_o), 32'd0);
      checkOutput("ib_done_vb_rdata", vb_rdata_o, 32'h0);
      checkOutput("ib_done_hata", 32'(hata_o), 32'd0);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
      settle();
      checkOutput("ib_after_valid", 32'(bus.iomem_valid), 32'd0);
      checkOutput("ib_after_ready", 32'(ib_ready_o), 32'd0);

      // ---- both requesters held: four data grants, then the instruction side
      for (int g = 0; g < 5; g++) begin
         applyStimulus(1'b1, 32'h0000_4000, 1'b1, 4'h0, 32'h0000_3000 + 32'(g * 4),
                       32'h0, 1'b0, 32'h0);
         settle();
         checkOutput($sformatf("arb_gap%0d", g), 32'(bus.iomem_valid), 32'd0);
         tick();
         checkOutput($sformatf("arb_valid%0d", g), 32'(bus.iomem_valid), 32'd1);
         checkOutput($sformatf("arb_addr%0d", g), bus.iomem_addr,
                     (g < 4) ? 32'h0000_3000 + 32'(g * 4) : 32'h0000_4000);
         applyStimulus(1'b1, 32'h0000_4000, 1'b1, 4'h0, 32'h0000_3000 + 32'(g * 4),
                       32'h0, 1'b1, 32'h0000_D000 + 32'(g));
         settle();
         checkOutput($sformatf("arb_vb_ready%0d", g), 32'(vb_ready_o), 32'(g < 4));
         checkOutput($sformatf("arb_ib_ready%0d", g), 32'(ib_ready_o), 32'(g == 4));
         tick();
      end

      // ---- memory ready with nothing on the bus is ignored
      applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFF);
      settle();
      checkOutput("stray_valid", 32'(bus.iomem_valid), 32'd0);
      checkOutput("stray_ib_ready", 32'(ib_ready_o), 32'd0);
      checkOutput("stray_vb_ready", 32'(vb_ready_o), 32'd0);
      tick();
      checkOutput("stray_valid2", 32'(bus.iomem_valid), 32'd0);

      // ---- data write with inputs disturbed while the bus stalls
      applyStimulus(1'b0, 32'h0, 1'b1, 4'b0011, 32'h2000_0004, 32'hAABB_CCDD, 1'b0, 32'h0);
      tick();
      applyStimulus(1'b1, 32'h0000_5000, 1'b0, 4'hF, 32'hFFFF_0000, 32'h1111_1111, 1'b0, 32'h0);
      for (int k = 0; k < 4; k++) begin
         settle();
         checkOutput($sformatf("hold_addr%0d", k), bus.iomem_addr, 32'h2000_0004);
         checkOutput($sformatf("hold_wstrb%0d", k), 32'(bus.iomem_wstrb), 32'h3);
         checkOutput($sformatf("hold_wdata%0d", k), bus.iomem_wdata, 32'hAABB_CCDD);
         checkOutput($sformatf("hold_vb_ready%0d", k), 32'(vb_ready_o), 32'd0);
         tick();
      end
      applyStimulus(1'b1, 32'h0000_5000, 1'b0, 4'hF, 32'hFFFF_0000, 32'h1111_1111, 1'b1, 32'hCAFE_F00D);
      settle();
      checkOutput("hold_done_vb_ready", 32'(vb_ready_o), 32'd1);
      checkOutput("hold_done_vb_rdata", vb_rdata_o, 32'hCAFE_F00D);
      checkOutput("hold_done_ib_ready", 32'(ib_ready_o), 32'd0);
      checkOutput("hold_done_ib_rdata", ib_rdata_o, 32'h0);
      tick();

      // ---- instruction read that never completes: aborts after 8 cycles
      applyStimulus(1'b1, 32'h0000_5000, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
      settle();
      checkOutput("tmo_gap", 32'(bus.iomem_valid), 32'd0);
      tick();
      for (int k = 1; k <= ZAMAN_ASIMI; k++) begin
         checkOutput($sformatf("tmo_valid%0d", k), 32'(bus.iomem_valid), 32'd1);
         checkOutput($sformatf("tmo_hata%0d", k), 32'(hata_o), 32'd0);
         checkOutput($sformatf("tmo_ib_ready%0d", k), 32'(ib_ready_o), 32'd0);
         tick();
      end
      checkOutput("tmo_end_valid", 32'(bus.iomem_valid), 32'd0);
      checkOutput("tmo_end_hata", 32'(hata_o), 32'd1);
      checkOutput("tmo_end_ib_ready", 32'(ib_ready_o), 32'd1);
      checkOutput("tmo_end_ib_rdata", ib_rdata_o, 32'h0);
      checkOutput("tmo_end_vb_ready", 32'(vb_ready_o), 32'd0);
      applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
      tick();
      checkOutput("tmo_post_hata", 32'(hata_o), 32'd0);
      checkOutput("tmo_post_ib_ready", 32'(ib_ready_o), 32'd0);
      checkOutput("tmo_post_valid", 32'(bus.iomem_valid), 32'd0);

      // ---- ready in the last waiting cycle is a normal completion
      applyStimulus(1'b0, 32'h0, 1'b1, 4'h0, 32'h0000_6000, 32'h0, 1'b0, 32'h0);
      tick();
      for (int k = 1; k < ZAMAN_ASIMI; k++) begin
         checkOutput($sformatf("edge_hata%0d", k), 32'(hata_o), 32'd0);
         tick();
      end
      applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0BAD_BEEF);
      settle();
      checkOutput("edge_vb_ready", 32'(vb_ready_o), 32'd1);
      checkOutput("edge_vb_rdata", vb_rdata_o, 32'h0BAD_BEEF);
      checkOutput("edge_hata", 32'(hata_o), 32'd0);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
      settle();
      checkOutput("edge_post_hata", 32'(hata_o), 32'd0);
      checkOutput("edge_post_vb_ready", 32'(vb_ready_o), 32'd0);
      checkOutput("edge_post_valid", 32'(bus.iomem_valid), 32'd0);

      // ---- reset during a data transaction with an instruction request pending
      applyStimulus(1'b1, 32'h0000_8000, 1'b1, 4'hF, 32'h0000_7000, 32'h55AA_55AA, 1'b0, 32'h0);
      tick();
      checkOutput("rsta_addr", bus.iomem_addr, 32'h0000_7000);
      checkOutput("rsta_wstrb", 32'(bus.iomem_wstrb), 32'hF);
      checkOutput("rsta_ac_cnt", 32'(dut.ac_cnt), 32'd1);
      tick();
      resetn = 1'b0;
      applyStimulus(1'b1, 32'h0000_8000, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0000_0001);
      settle();
      checkOutput("rsta_no_pulse", 32'(vb_ready_o), 32'd0);
      tick();
      checkOutput("rsta_valid", 32'(bus.iomem_valid), 32'd0);
      checkOutput("rsta_addr0", bus.iomem_addr, 32'h0);
      checkOutput("rsta_wdata0", bus.iomem_wdata, 32'h0);
      checkOutput("rsta_vb_ready", 32'(vb_ready_o), 32'd0);
      checkOutput("rsta_ib_ready", 32'(ib_ready_o), 32'd0);
      checkOutput("rsta_hata", 32'(hata_o), 32'd0);
      checkOutput("rsta_ac_zero", 32'(dut.ac_cnt), 32'd0);
      checkOutput("rsta_tmo_zero", 32'(dut.tmo_cnt), 32'd0);
      resetn = 1'b1;
      applyStimulus(1'b1, 32'h0000_8000, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
      tick();
      checkOutput("rstb_valid", 32'(bus.iomem_valid), 32'd1);
      checkOutput("rstb_addr", bus.iomem_addr, 32'h0000_8000);
      checkOutput("rstb_wstrb", 32'(bus.iomem_wstrb), 32'h0);
      applyStimulus(1'b1, 32'h0000_8000, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h600D_CAFE);
      settle();
      checkOutput("rstb_ib_ready", 32'(ib_ready_o), 32'd1);
      checkOutput("rstb_ib_rdata", ib_rdata_o, 32'h600D_CAFE);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
      settle();
      checkOutput("rstb_post_valid", 32'(bus.iomem_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/veriyolu_hakemi.md
VERIYOLU_HAKEMI -- requirements
Module: veriyolu_hakemi

Interface
REQ-001 Parameter AC_SINIR, default 4: max consecutive data grants while an instruction request waits.
REQ-002 Parameter ZAMAN_ASIMI, default 255: cycles an active transaction may wait for iomem_ready before abort.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 resetn  in  1  synchronous, active-low reset.
REQ-005 ib_valid_i  in  1  instruction-cache refill request (read-only), held until ib_ready_o.
REQ-006 ib_addr_i  in  32  instruction request address.
REQ-007 ib_ready_o  out  1  one-cycle completion pulse to instruction requester.
REQ-008 ib_rdata_o  out  32  read data, valid when ib_ready_o=1.
REQ-009 vb_valid_i  in  1  data-cache request (refill or write-back), held until vb_ready_o.
REQ-010 vb_wstrb_i  in  4  byte write strobes; 0 = read.
REQ-011 vb_addr_i  in  32  data request address.
REQ-012 vb_wdata_i  in  32  write data.
REQ-013 vb_ready_o  out  1  one-cycle completion pulse to data requester.
REQ-014 vb_rdata_o  out  32  read data, valid when vb_ready_o=1.
REQ-015 iomem_valid  out  1  bus request to external memory.
REQ-016 iomem_ready  in  1  bus completion from external memory.
REQ-017 iomem_wstrb / iomem_addr / iomem_wdata  out  4/32/32  bus request fields.
REQ-018 iomem_rdata  in  32  bus read data.
REQ-019 hata_o  out  1  one-cycle pulse when a transaction aborts on timeout.

Function
REQ-020 FSM states: BOS (idle), IB_AKTIF, VB_AKTIF; exactly one state active.
REQ-021 In BOS with no valid request, the FSM shall stay in BOS with iomem_valid=0.
REQ-022 In BOS, vb_valid_i=1 shall win over ib_valid_i=1, unless the starvation counter equals AC_SINIR, in which case the instruction request wins.
REQ-023 Starvation counter: increment on each VB grant while ib_valid_i=1; clear on every IB grant or when ib_valid_i=0 in BOS; saturate at AC_SINIR.
REQ-024 On grant, addr/wstrb/wdata of the winner shall be latched into registers that drive iomem_* for the whole transaction (IB grant latches wstrb=0, wdata=0).
REQ-025 iomem_valid shall rise the cycle after the grant decision (one-cycle request latency) and stay 1 until completion or abort.
REQ-026 iomem_* outputs shall not change while iomem_valid=1.
REQ-027 Completion: iomem_valid=1 and iomem_ready=1 in the same cycle -> combinational ready pulse to the owner only, owner rdata = iomem_rdata; next state BOS.
REQ-028 Non-owner ready shall be 0 in every cycle; rdata outputs read 0 when the matching ready is 0.
REQ-029 After any completion, iomem_valid shall be 0 for at least one cycle (BOS) before the next grant.
REQ-030 Timeout counter: cleared on grant, increments each active cycle with iomem_ready=0; when it reaches ZAMAN_ASIMI, the block shall drop iomem_valid, pulse the owner's ready with rdata=0, pulse hata_o, and return to BOS.
REQ-031 iomem_ready arriving in the same cycle as the timeout shall be treated as normal completion (no hata_o).
REQ-032 iomem_ready while iomem_valid=0 shall be ignored.
REQ-033 A requester dropping valid mid-transaction shall not abort the bus transaction; the completion pulse is still issued.

Reset
REQ-034 With resetn=0 at a clock edge: state=BOS, iomem_valid=0, iomem_wstrb=0, iomem_addr=0, iomem_wdata=0, ib_ready_o=0, vb_ready_o=0, hata_o=0, both counters=0.
REQ-035 Reset during an active transaction shall abandon it without a ready pulse; the first grant may occur in the first cycle after resetn returns to 1.

Verification
REQ-036 Single IB read: ib_valid_i=1, addr=0x0000_1000, iomem_ready after 3 cycles with rdata=0x1234_5678 -> iomem_valid 1 cycle after request, wstrb=0, ib_ready_o one pulse with 0x1234_5678, vb_ready_o=0.
REQ-037 Simultaneous requests, AC_SINIR=4, vb_valid_i held continuously -> 4 VB grants, then the 5th grant goes to IB; iomem_valid=0 for >=1 cycle between each.
REQ-038 VB write wstrb=4'b0011, addr=0x2000_0004, wdata=0xAABB_CCDD, iomem_ready held 0 and requester inputs changed mid-transfer -> iomem_* stay at latched values until ready.
REQ-039 Timeout, ZAMAN_ASIMI=8, iomem_ready never asserted -> after 8 active cycles: iomem_valid=0, hata_o pulse, owner ready pulse with rdata=0, FSM in BOS.
REQ-040 resetn=0 for one cycle during VB_AKTIF -> next cycle iomem_valid=0, no ready pulse, counters 0; a pending ib_valid_i is granted after reset releases.
